// File: rtl/pipe_mips32.sv
// pipe_mips32: five-stage MIPS32-subset pipeline (IF/ID/EX/MEM/WB) with unified memory,
// EX-stage forwarding, two-slot branch squash and a sticky halt.
module pipe_mips32 #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic halted
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [5:0] SUB = 6'b000001, AND = 6'b000010, OR = 6'b000011, SLT = 6'b000100;
  localparam logic [5:0] MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001, ADDI = 6'b001010;
  localparam logic [5:0] SUBI = 6'b001011, SLTI = 6'b001100, BNEQZ = 6'b001101, BEQZ = 6'b001110;
  localparam logic [5:0] HLT = 6'b111111;
  // An all-zero word is ADD R0,R0,R0, which never writes, so '0 doubles as the bubble.
  typedef struct packed {
    logic [31:0] ir, npc;
  } ifid_t;
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs, rt, dst;
    logic        we;
    logic [31:0] a, b, imm, npc;
  } idex_t;
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  dst;
    logic        we;
    logic [31:0] alu, b;
  } exmem_t;
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  dst;
    logic        we;
    logic [31:0] res;
  } memwb_t;
  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] PC, pc_d;
  logic HALTED, TAKEN_BRANCH;
  ifid_t ifid_q, ifid_d;
  idex_t idex_q, idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic halt_now, wb_en, mem_we, taken, is_r, is_i;
  logic [5:0] op;
  logic [4:0] rs, rt, rd, dst;
  logic [31:0] fa, fb, o2;
  function automatic logic [AW-1:0] wa(input logic [31:0] x);
    return AW'(x % 32'(MEM_DEPTH));
  endfunction
  assign halted = HALTED;
  always_comb begin
    halt_now = HALTED || memwb_q.op == HLT;
    wb_en = memwb_q.we && !HALTED;
    mem_we = exmem_q.op == SW && !halt_now;
    op = ifid_q.ir[31:26];
    rs = ifid_q.ir[25:21];
    rt = ifid_q.ir[20:16];
    rd = ifid_q.ir[15:11];
    is_r = op <= MUL;
    is_i = op inside {ADDI, SUBI, SLTI, LW};
    dst = is_r ? rd : rt;
    idex_d.op = op;
    idex_d.rs = rs;
    idex_d.rt = rt;
    idex_d.dst = dst;
    idex_d.we = (is_r || is_i) && dst != '0;
    idex_d.a = rs == '0 ? '0 : wb_en && memwb_q.dst == rs ? memwb_q.res : Reg[rs];
    idex_d.b = rt == '0 ? '0 : wb_en && memwb_q.dst == rt ? memwb_q.res : Reg[rt];
    idex_d.imm = {{16{ifid_q.ir[15]}}, ifid_q.ir[15:0]};
    idex_d.npc = ifid_q.npc;
    fa = exmem_q.we && exmem_q.dst == idex_q.rs ? exmem_q.alu :
         memwb_q.we && memwb_q.dst == idex_q.rs ? memwb_q.res : idex_q.a;
    fb = exmem_q.we && exmem_q.dst == idex_q.rt ? exmem_q.alu :
         memwb_q.we && memwb_q.dst == idex_q.rt ? memwb_q.res : idex_q.b;
    o2 = idex_q.op <= MUL ? fb : idex_q.imm;
    exmem_d.op = idex_q.op;
    exmem_d.dst = idex_q.dst;
    exmem_d.we = idex_q.we;
    exmem_d.b = fb;
    case (idex_q.op)
      SUB, SUBI: exmem_d.alu = fa - o2;
      AND:       exmem_d.alu = fa & o2;
      OR:        exmem_d.alu = fa | o2;
      SLT, SLTI: exmem_d.alu = {31'b0, $signed(fa) < $signed(o2)};
      MUL:       exmem_d.alu = fa * o2;
      default:   exmem_d.alu = fa + o2;
    endcase
    taken = !halt_now && ((idex_q.op == BEQZ && fa == '0) || (idex_q.op == BNEQZ && fa != '0));
    memwb_d.op = exmem_q.op;
    memwb_d.dst = exmem_q.dst;
    memwb_d.we = exmem_q.we;
    memwb_d.res = exmem_q.op == LW ? Mem[wa(exmem_q.alu)] : exmem_q.alu;
    ifid_d.ir = taken || halt_now ? '0 : Mem[wa(PC)];
    ifid_d.npc = PC + 32'd1;
    pc_d = halt_now ? PC : taken ? idex_q.npc + idex_q.imm : PC + 32'd1;
    if (taken) idex_d = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC <= '0;
      HALTED <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      ifid_q <= '0;
      idex_q <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      PC <= pc_d;
      HALTED <= halt_now;
      TAKEN_BRANCH <= taken;
      ifid_q <= ifid_d;
      idex_q <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end
  // Architectural arrays survive reset; only live pipeline contents may write them.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) Mem[wa(exmem_q.alu)] <= exmem_q.b;
    if (wb_en && !rst) Reg[memwb_q.dst] <= memwb_q.res;
  end
endmodule

// File: tb/tb_pipe_mips32.sv
// tb_pipe_mips32: directed and random programs checked against an instruction-level interpreter.
module tb_pipe_mips32;
  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011;
  localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
  localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110, HLT = 6'b111111, NOP = 6'b010000;
  localparam logic [31:0] HLT_W = 32'hfc000000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halted;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mr [0:31];
  logic [31:0] mm [0:1023];
  logic [31:0] p1 [0:8] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                            32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

  pipe_mips32 #(.MEM_DEPTH(1024)) dut (.clk(clk), .rst(rst), .halted(halted));

  always #5 clk = ~clk;

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rd, rs, rt);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] ii(input logic [5:0] op, input logic [4:0] rt, rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Sequential ISA interpreter: one instruction at a time, no pipeline notion.
  task automatic model();
    logic [31:0] pc, ir, a, b, imm, res;
    logic [5:0] op;
    logic [4:0] dst;
    pc = 0;
    for (int s = 0; s < 4000; s++) begin
      ir = mm[pc % 1024];
      op = ir[31:26];
      a = mr[ir[25:21]];
      b = mr[ir[20:16]];
      imm = {{16{ir[15]}}, ir[15:0]};
      pc = pc + 1;
      if (op == HLT) break;
      dst = op <= MUL ? ir[15:11] : ir[20:16];
      res = 0;
      case (op)
        ADD:   res = a + b;
        SUB:   res = a - b;
        AND_:  res = a & b;
        OR_:   res = a | b;
        SLT:   res = $signed(a) < $signed(b) ? 32'd1 : 32'd0;
        MUL:   res = a * b;
        ADDI:  res = a + imm;
        SUBI:  res = a - imm;
        SLTI:  res = $signed(a) < $signed(imm) ? 32'd1 : 32'd0;
        LW:    res = mm[(a + imm) % 1024];
        SW:    begin mm[(a + imm) % 1024] = b; dst = 0; end
        BEQZ:  begin if (a == 0) pc = pc + imm; dst = 0; end
        BNEQZ: begin if (a != 0) pc = pc + imm; dst = 0; end
        default: dst = 0;
      endcase
      if (dst != 0) mr[dst] = res;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mm[i] = 32'h0;
  endtask

  task automatic regs_k();
    for (int r = 0; r < 32; r++) mr[r] = 32'(r);
  endtask

  task automatic start();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) dut.Mem[i] = mm[i];
    for (int r = 0; r < 32; r++) dut.Reg[r] = mr[r];
    @(negedge clk);
    chk("rst_pc", dut.PC, 32'h0);
    chk("rst_halted", {31'b0, dut.HALTED}, 32'h0);
    chk("rst_taken", {31'b0, dut.TAKEN_BRANCH}, 32'h0);
    chk("rst_port", {31'b0, halted}, 32'h0);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int cyc;
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("halt_seen", {31'b0, halted}, 32'h1);
  endtask

  task automatic pc_frozen();
    logic [31:0] p;
    p = dut.PC;
    repeat (5) @(negedge clk);
    chk("pc_frozen", dut.PC, p);
    chk("halt_sticky", {31'b0, dut.HALTED}, 32'h1);
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < 32; r++) chk($sformatf("%s R%0d", tag, r), dut.Reg[r], mr[r]);
    for (int i = 0; i < 1024; i++) chk($sformatf("%s M%0d", tag, i), dut.Mem[i], mm[i]);
  endtask

  initial begin
    int L, i, k, tb_cnt, cyc;
    logic [15:0] imm;
    // given program, fixed deadline
    clear_mem(); regs_k();
    for (int j = 0; j < 9; j++) mm[j] = p1[j];
    start();
    repeat (20) @(negedge clk);
    chk("p1_halted", {31'b0, dut.HALTED}, 32'h1);
    chk("p1_port", {31'b0, halted}, 32'h1);
    chk("p1_R1", dut.Reg[1], 32'd10);
    chk("p1_R2", dut.Reg[2], 32'd20);
    chk("p1_R3", dut.Reg[3], 32'd25);
    chk("p1_R4", dut.Reg[4], 32'd30);
    chk("p1_R5", dut.Reg[5], 32'd55);
    pc_frozen();
    model(); check_all("p1");
    // reset asserted in cycle 3 of the same program
    clear_mem(); regs_k();
    for (int j = 0; j < 9; j++) mm[j] = p1[j];
    start();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_pc", dut.PC, 32'h0);
    chk("mid_rst_halted", {31'b0, dut.HALTED}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      for (int r = 1; r <= 5; r++) chk($sformatf("mid_rst R%0d", r), dut.Reg[r], 32'(r));
    end
    rst = 1'b0;
    wait_halt(60);
    chk("rerun_R5", dut.Reg[5], 32'd55);
    model(); check_all("rerun");
    // back-to-back dependency
    clear_mem(); regs_k();
    mm[0] = ii(ADDI, 1, 0, 16'd7); mm[1] = ri(ADD, 2, 1, 1); mm[2] = ri(ADD, 3, 2, 1); mm[3] = HLT_W;
    start(); wait_halt(60);
    chk("dep_R2", dut.Reg[2], 32'd14);
    chk("dep_R3", dut.Reg[3], 32'd21);
    model(); check_all("dep");
    // load / store
    clear_mem(); regs_k();
    mm[120] = 32'd85;
    mm[0] = ii(ADDI, 1, 0, 16'd120); mm[1] = 32'h0ce77800; mm[2] = ii(LW, 2, 1, 16'd0);
    mm[3] = 32'h0ce77800; mm[4] = ii(ADDI, 2, 2, 16'd45); mm[5] = ii(SW, 2, 1, 16'd1); mm[6] = HLT_W;
    start(); wait_halt(60);
    chk("mem_M121", dut.Mem[121], 32'd130);
    chk("mem_R2", dut.Reg[2], 32'd130);
    model(); check_all("mem");
    // factorial loop
    clear_mem(); regs_k();
    mm[200] = 32'd5;
    mm[0] = ii(ADDI, 10, 0, 16'd200); mm[1] = ii(LW, 3, 10, 16'd0); mm[2] = ii(ADDI, 2, 0, 16'd1);
    mm[3] = ri(MUL, 2, 2, 3); mm[4] = ii(SUBI, 3, 3, 16'd1); mm[5] = ii(BNEQZ, 0, 3, 16'hfffd);
    mm[6] = ii(ADDI, 7, 7, 16'd1); mm[7] = ii(ADDI, 8, 8, 16'd1); mm[8] = ii(SW, 2, 10, 16'hfffe);
    mm[9] = HLT_W;
    start();
    tb_cnt = 0; cyc = 0;
    while (!halted && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (dut.TAKEN_BRANCH) tb_cnt++;
    end
    chk("fact_halt", {31'b0, halted}, 32'h1);
    chk("fact_taken", 32'(tb_cnt), 32'd4);
    chk("fact_M198", dut.Mem[198], 32'd120);
    chk("fact_R7", dut.Reg[7], 32'd8);
    chk("fact_R8", dut.Reg[8], 32'd9);
    model(); check_all("fact");
    // nothing after HLT may retire
    clear_mem(); regs_k();
    mm[0] = HLT_W; mm[1] = ii(ADDI, 6, 0, 16'd99);
    start(); wait_halt(40);
    pc_frozen();
    chk("hblk_R6", dut.Reg[6], 32'd6);
    // random programs
    for (int t = 0; t < 20; t++) begin
      clear_mem();
      for (int r = 0; r < 32; r++) mr[r] = (r == 0) ? 32'h0 : $urandom;
      for (int j = 600; j < 632; j++) mm[j] = $urandom;
      L = $urandom_range(20, 40);
      i = 0;
      while (i < L) begin
        k = $urandom_range(0, 9);
        if (k <= 4) mm[i] = ri(6'($urandom_range(0, 5)), 5'($urandom), 5'($urandom), 5'($urandom));
        else if (k <= 6) mm[i] = ii(6'($urandom_range(10, 12)), 5'($urandom), 5'($urandom), 16'($urandom));
        else if (k == 7) begin
          mm[i] = ii(LW, 5'($urandom), 0, 16'(600 + $urandom_range(0, 31)));
          i++;
          mm[i] = {NOP, 26'h0};
        end else if (k == 8) mm[i] = ii(SW, 5'($urandom), 0, 16'(600 + $urandom_range(0, 31)));
        else begin
          imm = 16'($urandom_range(0, 2));
          if (32'(imm) > 32'(L - i - 1)) imm = 16'd0;
          mm[i] = ii($urandom_range(0, 1) ? BEQZ : BNEQZ, 0, 5'($urandom), imm);
        end
        i++;
      end
      mm[i] = HLT_W;
      mm[i + 1] = ii(ADDI, 6, 0, 16'd99);
      mm[i + 2] = ii(SW, 5, 0, 16'd610);
      start(); wait_halt(400);
      pc_frozen();
      model(); check_all($sformatf("rnd%0d", t));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
